// File: rtl/sync_bus_capture.sv
// sync_bus_capture: destination-side capture stage of the CDC data-sync path.
// When the single-cycle PULSE strobe arrives, the quasi-static UNSYNC_BUS is
// sampled into the registered SYNC_BUS, and ENABLE_PULSE is raised for one cycle
// in step with it. Every captured word is also pushed into a small
// first-word-fall-through FIFO with a valid/ready drain port. A word that
// arrives while the FIFO is full, with no pop in that cycle, is dropped and
// counted in a saturating overflow counter.
//
// Ports:
//   CLK, RST             clock (rising edge); asynchronous reset, active-high
//   PULSE, UNSYNC_BUS    capture strobe and the source-domain data word
//   SYNC_BUS             last captured word
//   ENABLE_PULSE         one-cycle strobe, high in the cycle SYNC_BUS takes a new word
//   OUT_VALID/OUT_DATA   FIFO head (OUT_DATA is combinational from storage)
//   OUT_READY            consumer accepts the head word this cycle
//   FIFO_COUNT           FIFO occupancy
//   OVF_COUNT            number of dropped words, saturating
// Optional (macro SYNC_CAPTURE_PARITY_EN):
//   UNSYNC_PAR           even parity of UNSYNC_BUS, stored with each FIFO entry
//   OUT_PAR_ERR          head word disagrees with its stored parity
module sync_bus_capture #(
   parameter int unsigned BUS_WIDTH  = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          PULSE,
   input  logic [BUS_WIDTH-1:0]          UNSYNC_BUS,
   output logic [BUS_WIDTH-1:0]          SYNC_BUS,
   output logic                          ENABLE_PULSE,
   output logic                          OUT_VALID,
   output logic [BUS_WIDTH-1:0]          OUT_DATA,
   input  logic                          OUT_READY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
`ifdef SYNC_CAPTURE_PARITY_EN
   input  logic                          UNSYNC_PAR,
   output logic                          OUT_PAR_ERR,
`endif
   output logic [CNT_WIDTH-1:0]          OVF_COUNT
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);

   logic [BUS_WIDTH-1:0] sync_bus_q, sync_bus_d;
   logic                 enable_q, enable_d;
   logic [BUS_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [BUS_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]        wptr_q, wptr_d;
   logic [AW-1:0]        rptr_q, rptr_d;
   logic [AW:0]          count_q, count_d;
   logic                 out_valid_q, out_valid_d;
   logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
   logic                 full, pop, push, drop;
`ifdef SYNC_CAPTURE_PARITY_EN
   logic [FIFO_DEPTH-1:0] par_q, par_d;
`endif

   always_comb begin
      // Occupancy, not pointer equality, decides full/empty.
      full = (count_q == FullCnt);
      pop  = out_valid_q && OUT_READY;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push = PULSE && (!full || pop);
      drop = PULSE && full && !pop;

      sync_bus_d = sync_bus_q;
      enable_d   = PULSE;
      if (PULSE) begin
         sync_bus_d = UNSYNC_BUS;
      end

      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
         mem_d[wptr_q] = UNSYNC_BUS;
         wptr_d        = wptr_q + AW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + AW'(1);
      end

      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      out_valid_d = (count_d != '0);

      ovf_d = ovf_q;
      if (drop && (ovf_q != '1)) begin
         ovf_d = ovf_q + CNT_WIDTH'(1);
      end
   end

`ifdef SYNC_CAPTURE_PARITY_EN
   always_comb begin
      par_d = par_q;
      if (push) begin
         par_d[wptr_q] = UNSYNC_PAR;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         par_q <= '0;
      end else begin
         par_q <= par_d;
      end
   end

   assign OUT_PAR_ERR = out_valid_q && ((^mem_q[rptr_q]) != par_q[rptr_q]);
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_bus_q  <= '0;
         enable_q    <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         sync_bus_q  <= sync_bus_d;
         enable_q    <= enable_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign SYNC_BUS     = sync_bus_q;
   assign ENABLE_PULSE = enable_q;
   assign OUT_VALID    = out_valid_q;
   assign OUT_DATA     = mem_q[rptr_q];
   assign FIFO_COUNT   = count_q;
   assign OVF_COUNT    = ovf_q;

endmodule
